add_result_checker: RTL and testbench

ADD_RESULT_CHECKER -- requirements
Module: add_result_checker

---
 rtl/add_result_checker_pkg.sv | 23 ++
 rtl/add_result_checker_chk_delay_line.sv | 49 ++++
 rtl/add_result_checker.sv | 138 +++++++++++++
 tb/tb_add_result_checker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/add_result_checker_pkg.sv
// Shared definitions for the adder result checker: FSM encoding, result
// width and default parameter values, plus the reference sum function.
package add_result_checker_pkg;

  // {carry, sum[7:0]}
  localparam int RES_W       = 9;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECKING = 2'd1,
    ST_FAILED   = 2'd2
  } chk_state_e;

  // Zero-extended 9-bit reference sum of two bytes plus carry-in.
  function automatic logic [RES_W-1:0] expected_sum(input logic [7:0] op_a,
                                                    input logic [7:0] op_b,
                                                    input logic       c_in);
    return {1'b0, op_a} + {1'b0, op_b} + {{(RES_W-1){1'b0}}, c_in};
  endfunction

endpackage

// File: rtl/add_result_checker_chk_delay_line.sv
// Fixed-depth valid/data shift pipeline. Accepts an entry every cycle, never
// stalls. flush zeroes every valid bit and drops the incoming entry.
module chk_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  // Next-state: shift by one stage; flush kills all valid bits.
  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    if (!flush) begin
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/add_result_checker.sv
// Checks an external 8-bit adder: computes the expected {carry,sum} for each
// presented transaction, delays it by LATENCY cycles, compares it with the
// returned {cout,sout}, and keeps saturating pass/error tallies, a capture of
// the first failing pair and a small IDLE/CHECKING/FAILED status FSM.
// Handshake: in_valid qualifies a/b/cin for one cycle only; there is no ready,
// every valid cycle is accepted. chk_valid is a one-cycle pulse LATENCY+1
// cycles after the transaction, and mismatch is only meaningful with it.
// LATENCY is legal over 1..4.
module add_result_checker
  import add_result_checker_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             cin,
  input  logic [7:0]       sout,
  input  logic             cout,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [RES_W-1:0] first_err_exp,
  output logic [RES_W-1:0] first_err_got,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             dl_valid;
  logic [RES_W-1:0] dl_exp;
  logic [RES_W-1:0] got;
  logic             cmp_fire;
  logic             cmp_bad;

  chk_state_e       state_q, state_d;
  logic             chk_valid_q, chk_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [RES_W-1:0] fexp_q, fexp_d;
  logic [RES_W-1:0] fgot_q, fgot_d;

  chk_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (RES_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (clear),
    .in_valid  (in_valid),
    .in_data   (expected_sum(a, b, cin)),
    .out_valid (dl_valid),
    .out_data  (dl_exp)
  );

  // sout/cout only matter in the cycle an entry emerges; clear suppresses it.
  assign got      = {cout, sout};
  assign cmp_fire = dl_valid && !clear;
  assign cmp_bad  = cmp_fire && (got != dl_exp);

  // Comparator result registers, counters and first-error capture.
  always_comb begin
    chk_valid_d = cmp_fire;
    mismatch_d  = cmp_bad;
    pass_d      = pass_q;
    err_d       = err_q;
    fexp_d      = fexp_q;
    fgot_d      = fgot_q;
    if (clear) begin
      pass_d = '0;
      err_d  = '0;
      fexp_d = '0;
      fgot_d = '0;
    end else begin
      if (cmp_fire && !cmp_bad && pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
      if (cmp_bad && err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
      // FAILED means a mismatch has already been captured since reset/clear.
      if (cmp_bad && state_q != ST_FAILED) begin
        fexp_d = dl_exp;
        fgot_d = got;
      end
    end
  end

  // Status FSM next-state.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (cmp_bad) state_d = ST_FAILED;
                     else if (in_valid) state_d = ST_CHECKING;
        ST_CHECKING: if (cmp_bad) state_d = ST_FAILED;
        ST_FAILED:   state_d = ST_FAILED;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // All checker state; asynchronous reset zeroes every output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_q      <= '0;
      err_q       <= '0;
      fexp_q      <= '0;
      fgot_q      <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= chk_valid_d;
      mismatch_q  <= mismatch_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fexp_q      <= fexp_d;
      fgot_q      <= fgot_d;
    end
  end

  assign chk_valid     = chk_valid_q;
  assign mismatch      = mismatch_q;
  assign err_sticky    = (state_q == ST_FAILED);
  assign pass_count    = pass_q;
  assign err_count     = err_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;
  assign state         = state_q;

endmodule

// File: tb/tb_add_result_checker.sv
// Directed bench: u1 is the default LATENCY=1 / CNT_W=16 checker, u3 is a
// LATENCY=3 / CNT_W=4 checker. The bench plays the adder under test by
// driving sout/cout with hand-chosen returned values at the right cycle.
module tb_add_result_checker;

  logic clk;
  logic reset;

  logic        c1_clear, c1_in_valid, c1_cin, c1_cout;
  logic [7:0]  c1_a, c1_b, c1_sout;
  logic        o1_chk, o1_mis, o1_sticky;
  logic [15:0] o1_pass, o1_err;
  logic [8:0]  o1_fexp, o1_fgot;
  logic [1:0]  o1_state;

  logic        c3_clear, c3_in_valid, c3_cin, c3_cout;
  logic [7:0]  c3_a, c3_b, c3_sout;
  logic        o3_chk, o3_mis, o3_sticky;
  logic [3:0]  o3_pass, o3_err;
  logic [8:0]  o3_fexp, o3_fgot;
  logic [1:0]  o3_state;

  int checks = 0;
  int passes = 0;

  add_result_checker #(.LATENCY(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .clear(c1_clear), .in_valid(c1_in_valid),
    .a(c1_a), .b(c1_b), .cin(c1_cin), .sout(c1_sout), .cout(c1_cout),
    .chk_valid(o1_chk), .mismatch(o1_mis), .err_sticky(o1_sticky),
    .pass_count(o1_pass), .err_count(o1_err),
    .first_err_exp(o1_fexp), .first_err_got(o1_fgot), .state(o1_state)
  );

  add_result_checker #(.LATENCY(3), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset), .clear(c3_clear), .in_valid(c3_in_valid),
    .a(c3_a), .b(c3_b), .cin(c3_cin), .sout(c3_sout), .cout(c3_cout),
    .chk_valid(o3_chk), .mismatch(o3_mis), .err_sticky(o3_sticky),
    .pass_count(o3_pass), .err_count(o3_err),
    .first_err_exp(o3_fexp), .first_err_got(o3_fgot), .state(o3_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: present one cycle of inputs, return #1 after the closing edge.
  task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [8:0] ret, input logic clr);
    c1_in_valid = v; c1_a = a; c1_b = b; c1_cin = ci;
    {c1_cout, c1_sout} = ret; c1_clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic drive3(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [8:0] ret, input logic clr);
    c3_in_valid = v; c3_a = a; c3_b = b; c3_cin = ci;
    {c3_cout, c3_sout} = ret; c3_clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive1(0, 0, 0, 0, 9'h0, 0);
    drive3(0, 0, 0, 0, 9'h0, 0);
    checks++; if ({o1_chk, o1_mis, o1_sticky, o1_state} !== 5'b0) $display("FAIL reset_u1_flags: got %b required 0", {o1_chk, o1_mis, o1_sticky, o1_state}); else passes++;
    checks++; if ({o1_pass, o1_err, o1_fexp, o1_fgot} !== 50'b0) $display("FAIL reset_u1_regs: got %h required 0", {o1_pass, o1_err, o1_fexp, o1_fgot}); else passes++;
    checks++; if ({o3_chk, o3_mis, o3_sticky, o3_state, o3_pass, o3_err, o3_fexp, o3_fgot} !== 31'b0) $display("FAIL reset_u3_all: got %h required 0", {o3_chk, o3_mis, o3_sticky, o3_state, o3_pass, o3_err, o3_fexp, o3_fgot}); else passes++;
    reset = 1'b1;
    drive1(0, 0, 0, 0, 9'h0, 0);
  endtask

  task automatic test_single_pass();
    drive1(1, 8'd5, 8'd10, 0, 9'h000, 0);
    checks++; if (o1_state !== 2'd1 || o1_chk !== 1'b0) $display("FAIL single_accept: state %0d chk %b required 1 0", o1_state, o1_chk); else passes++;
    drive1(0, 0, 0, 0, 9'h00F, 0);
    checks++; if (o1_chk !== 1'b1 || o1_mis !== 1'b0) $display("FAIL single_pulse: chk %b mis %b required 1 0", o1_chk, o1_mis); else passes++;
    checks++; if (o1_pass !== 16'd1 || o1_err !== 16'd0) $display("FAIL single_count: pass %0d err %0d required 1 0", o1_pass, o1_err); else passes++;
    drive1(0, 0, 0, 0, 9'h1FF, 0);
    checks++; if (o1_chk !== 1'b0 || o1_pass !== 16'd1) $display("FAIL idle_ignore: chk %b pass %0d required 0 1", o1_chk, o1_pass); else passes++;
  endtask

  task automatic test_clear_idle();
    drive1(0, 0, 0, 0, 9'h0, 1);
    checks++; if (o1_state !== 2'd0 || o1_pass !== 16'd0) $display("FAIL clear_idle: state %0d pass %0d required 0 0", o1_state, o1_pass); else passes++;
  endtask

  task automatic test_carry_pass();
    drive1(1, 8'd255, 8'd1, 0, 9'h000, 0);
    drive1(1, 8'd170, 8'd85, 1, 9'h100, 0);
    checks++; if (o1_chk !== 1'b1 || o1_mis !== 1'b0 || o1_pass !== 16'd1) $display("FAIL carry_first: chk %b mis %b pass %0d required 1 0 1", o1_chk, o1_mis, o1_pass); else passes++;
    drive1(0, 0, 0, 0, 9'h100, 0);
    checks++; if (o1_chk !== 1'b1 || o1_mis !== 1'b0 || o1_pass !== 16'd2) $display("FAIL carry_second: chk %b mis %b pass %0d required 1 0 2", o1_chk, o1_mis, o1_pass); else passes++;
  endtask

  task automatic test_mismatch();
    drive1(1, 8'd0, 8'd7, 1, 9'h000, 0);
    drive1(0, 0, 0, 0, 9'h007, 0);
    checks++; if (o1_chk !== 1'b1 || o1_mis !== 1'b1) $display("FAIL mis_pulse: chk %b mis %b required 1 1", o1_chk, o1_mis); else passes++;
    checks++; if (o1_err !== 16'd1 || o1_pass !== 16'd2) $display("FAIL mis_count: err %0d pass %0d required 1 2", o1_err, o1_pass); else passes++;
    checks++; if (o1_fexp !== 9'h008 || o1_fgot !== 9'h007) $display("FAIL mis_capture: exp %h got %h required 008 007", o1_fexp, o1_fgot); else passes++;
    checks++; if (o1_state !== 2'd2 || o1_sticky !== 1'b1) $display("FAIL mis_state: state %0d sticky %b required 2 1", o1_state, o1_sticky); else passes++;
    drive1(0, 0, 0, 0, 9'h000, 0);
    checks++; if (o1_chk !== 1'b0 || o1_mis !== 1'b0) $display("FAIL mis_one_cycle: chk %b mis %b required 0 0", o1_chk, o1_mis); else passes++;
  endtask

  task automatic test_second_error();
    drive1(1, 8'd1, 8'd2, 0, 9'h000, 0);
    drive1(1, 8'd3, 8'd4, 0, 9'h004, 0);
    checks++; if (o1_mis !== 1'b1 || o1_err !== 16'd2) $display("FAIL err2_count: mis %b err %0d required 1 2", o1_mis, o1_err); else passes++;
    checks++; if (o1_fexp !== 9'h008 || o1_fgot !== 9'h007) $display("FAIL err2_hold: exp %h got %h required 008 007", o1_fexp, o1_fgot); else passes++;
    drive1(0, 0, 0, 0, 9'h007, 0);
    checks++; if (o1_chk !== 1'b1 || o1_mis !== 1'b0 || o1_pass !== 16'd3) $display("FAIL failed_counts: chk %b mis %b pass %0d required 1 0 3", o1_chk, o1_mis, o1_pass); else passes++;
    checks++; if (o1_state !== 2'd2 || o1_sticky !== 1'b1) $display("FAIL failed_hold: state %0d sticky %b required 2 1", o1_state, o1_sticky); else passes++;
  endtask

  task automatic test_clear_priority();
    drive1(1, 8'd1, 8'd1, 0, 9'h000, 1);
    checks++; if (o1_state !== 2'd0 || o1_sticky !== 1'b0 || o1_chk !== 1'b0) $display("FAIL clr_state: state %0d sticky %b chk %b required 0 0 0", o1_state, o1_sticky, o1_chk); else passes++;
    checks++; if ({o1_pass, o1_err, o1_fexp, o1_fgot} !== 50'b0) $display("FAIL clr_regs: got %h required 0", {o1_pass, o1_err, o1_fexp, o1_fgot}); else passes++;
    drive1(0, 0, 0, 0, 9'h002, 0);
    checks++; if (o1_chk !== 1'b0 || o1_pass !== 16'd0) $display("FAIL clr_drop: chk %b pass %0d required 0 0", o1_chk, o1_pass); else passes++;
  endtask

  // LATENCY=3: two in flight, clear held over the third and fourth.
  task automatic test_flush_l3();
    int pulses = 0;
    for (int k = 0; k < 9; k++) begin
      logic [8:0] ret;
      ret = (k >= 3) ? 9'(30 + k - 3) : 9'h0;
      drive3(k < 4, 8'(10 + k), 8'd20, 0, ret, (k == 2 || k == 3));
      if (o3_chk === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL flush_pulses: got %0d required 0", pulses); else passes++;
    checks++; if (o3_pass !== 4'd0 || o3_err !== 4'd0 || o3_state !== 2'd0) $display("FAIL flush_regs: pass %0d err %0d state %0d required 0 0 0", o3_pass, o3_err, o3_state); else passes++;
  endtask

  // 20 back-to-back passes at LATENCY=3; pulses land 4 cycles after each.
  task automatic test_back_to_back_saturate();
    int bad_slots = 0;
    for (int k = 0; k < 24; k++) begin
      logic [8:0] ret;
      logic       want;
      int         j;
      j    = k - 3;
      ret  = (j >= 0 && j < 20) ? 9'(j * 3 + 100 + (j & 1)) : 9'h0;
      drive3(k < 20, 8'(k * 3), 8'd100, k[0], ret, 0);
      want = (k >= 3 && k < 23);
      if (o3_chk !== want || o3_mis !== 1'b0) begin
        bad_slots++;
        $display("FAIL b2b_slot%0d: chk %b mis %b required %b 0", k, o3_chk, o3_mis, want);
      end
    end
    checks++; if (bad_slots !== 0) $display("FAIL b2b_slots: got %0d bad required 0", bad_slots); else passes++;
    checks++; if (o3_pass !== 4'd15 || o3_err !== 4'd0) $display("FAIL saturate: pass %0d err %0d required 15 0", o3_pass, o3_err); else passes++;
  endtask

  task automatic test_reset_midstream();
    int pulses = 0;
    drive3(1, 8'd1, 8'd1, 0, 9'h0, 0);
    drive3(1, 8'd2, 8'd2, 0, 9'h0, 0);
    c3_in_valid = 1'b1; c3_a = 8'd3; c3_b = 8'd3;
    #2 reset = 1'b0;
    #1;
    checks++; if ({o3_chk, o3_mis, o3_sticky, o3_state, o3_pass, o3_err} !== 13'b0) $display("FAIL async_reset: got %h required 0", {o3_chk, o3_mis, o3_sticky, o3_state, o3_pass, o3_err}); else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [8:0] ret;
      ret = (k < 3) ? 9'(2 * (k + 1)) : 9'h0;
      drive3(0, 0, 0, 0, ret, 0);
      if (o3_chk === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || o3_pass !== 4'd0) $display("FAIL post_reset_stale: pulses %0d pass %0d required 0 0", pulses, o3_pass); else passes++;
    drive3(1, 8'd40, 8'd2, 1, 9'h0, 0);
    drive3(0, 0, 0, 0, 9'h0, 0);
    drive3(0, 0, 0, 0, 9'h0, 0);
    checks++; if (o3_chk !== 1'b0) $display("FAIL post_reset_early: chk %b required 0", o3_chk); else passes++;
    drive3(0, 0, 0, 0, 9'h02B, 0);
    checks++; if (o3_chk !== 1'b1 || o3_pass !== 4'd1) $display("FAIL post_reset_new: chk %b pass %0d required 1 1", o3_chk, o3_pass); else passes++;
  endtask

  initial begin
    reset = 1'b0;
    c1_clear = 0; c1_in_valid = 0; c1_a = 0; c1_b = 0; c1_cin = 0; c1_sout = 0; c1_cout = 0;
    c3_clear = 0; c3_in_valid = 0; c3_a = 0; c3_b = 0; c3_cin = 0; c3_sout = 0; c3_cout = 0;
    test_reset();
    test_single_pass();
    test_clear_idle();
    test_carry_pass();
    test_mismatch();
    test_second_error();
    test_clear_priority();
    test_flush_l3();
    test_back_to_back_saturate();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
